// File: rtl/mem_regfile_pkg.sv
// mem_regfile_pkg: state type and default parameters shared by mem_regfile and its clear sequencer
package mem_regfile_pkg;
    typedef enum logic {CLEAR, IDLE} state_t;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_INIT_VAL = 0;
endpackage

// File: rtl/mem_regfile_clr_seq.sv
// mem_regfile_clr_seq: CLEAR/IDLE state machine with an address counter that walks every entry once
module mem_regfile_clr_seq
    import mem_regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clear_en,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);
    state_t state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // The extra counter bit sets exactly when the last entry has been written.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            state_d = cnt_inc[ADDR_W] ? IDLE : CLEAR;
            cnt_d   = cnt_inc[ADDR_W] ? '0 : cnt_inc;
        end else if (clear_en) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end
    assign busy     = state_q == CLEAR;
    assign clr_we   = busy;
    assign clr_addr = cnt_q[ADDR_W-1:0];
endmodule

// File: rtl/mem_regfile.sv
// mem_regfile: DEPTH x DATA_W register file with registered reads and a hardware clear sequencer.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-cycle same-address read/write.
module mem_regfile
    import mem_regfile_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic              read_rdy,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic              clear_en,
    output logic              clear_rdy
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic              clr_we, busy, wr_fire, rd_fire, fwd, rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    mem_regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear_en (clear_en),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );
    assign write_rdy = !busy;
    assign read_rdy  = !busy;
    assign clear_rdy = !busy;
    // A clear request takes priority over a write in the same cycle.
    assign wr_fire = write_en && write_rdy && !clear_en;
    assign rd_fire = read_en && read_rdy;
`ifdef REGFILE_BYPASS_EN
    assign fwd = wr_fire && write_address == read_address;
`else
    assign fwd = 1'b0;
`endif
    always_comb begin
        mem_d = mem_q;
        if (clr_we)
            mem_d[clr_addr] = INIT_VAL;
        else if (wr_fire)
            mem_d[write_address] = write_data;
        rd_valid_d = rd_fire;
        rd_data_d  = rd_fire ? (fwd ? write_data : mem_q[read_address]) : rd_data_q;
    end
    always_ff @(posedge CLK)
        mem_q <= mem_d;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
    assign read_valid = rd_valid_q;
    assign read_data  = rd_data_q;
endmodule

// File: tb/tb_mem_regfile.sv
// tb_mem_regfile: scoreboard bench for mem_regfile; expected read data is queued at issue and popped on read_valid
module tb_mem_regfile;
    localparam int AW = 3;
    localparam int DW = 1;
    localparam int DEPTH = 8;
    localparam logic [DW-1:0] INIT = '0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic CLK = 1'b0, RST_N = 1'b0;
    logic [AW-1:0] write_address = '0, read_address = '0;
    logic [DW-1:0] write_data = '0;
    logic write_en = 1'b0, read_en = 1'b0, clear_en = 1'b0;
    logic write_rdy, read_rdy, read_valid, clear_rdy;
    logic [DW-1:0] read_data;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_data;
    int clr_left, n_tests, n_fail;
    mem_regfile #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(INIT)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_rdy      (read_rdy),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .clear_en      (clear_en),
        .clear_rdy     (clear_rdy)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_rdy(input logic exp);
        check("write_rdy", write_rdy, exp);
        check("read_rdy", read_rdy, exp);
        check("clear_rdy", clear_rdy, exp);
    endtask
    // Called at a falling edge; drives one cycle, advances the model, checks after the rising edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic ce);
        logic rdy, rf, wf;
        logic [DW-1:0] rv;
        write_en = we; write_address = wa; write_data = wd;
        read_en = re; read_address = ra; clear_en = ce;
        rdy = clr_left == 0;
        rf = re && rdy;
        wf = we && rdy && !ce;
        rv = (BYP && wf && wa == ra) ? wd : model[ra];
        if (rf) sb.push_back(rv);
        if (clr_left > 0) begin
            model[DEPTH-clr_left] = INIT;
            clr_left--;
        end else if (ce && rdy)
            clr_left = DEPTH;
        else if (wf)
            model[wa] = wd;
        @(posedge CLK);
        #1;
        check("read_valid", read_valid, rf);
        if (read_valid && sb.size() > 0) last_data = sb.pop_front();
        check("read_data", read_data, last_data);
        check_rdy(clr_left == 0);
        @(negedge CLK);
    endtask
    task automatic do_reset();
        RST_N = 1'b0;
        write_en = 1'b0; read_en = 1'b0; clear_en = 1'b0;
        #1;
        check_rdy(1'b0);
        check("rst_valid", read_valid, 1'b0);
        check("rst_data", read_data, '0);
        sb.delete();
        last_data = '0;
        clr_left = DEPTH;
        @(negedge CLK);
        check_rdy(1'b0);
        check("rst_valid_hold", read_valid, 1'b0);
        RST_N = 1'b1;
    endtask
    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
    endtask
    initial begin
        n_tests = 0;
        n_fail = 0;
        @(negedge CLK);
        do_reset();
        // writes and reads offered during the post-reset clear must be ignored
        for (int k = 0; k < DEPTH; k++) step(1'b1, AW'(k), 1'b1, 1'b1, AW'(k), 1'b0);
        read_all();
        step(1'b1, 3'd5, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 3'd5, 1'b0);
        step(1'b0, '0, '0, 1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0);
        step(1'b0, '0, '0, 1'b1, 3'd3, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b1, AW'(k), 1'b1, 1'b0, '0, 1'b0);
        read_all();
        step(1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 1'b1);
        for (int k = 0; k < DEPTH; k++) step(1'b1, 3'd2, 1'b1, 1'b1, AW'(k), 1'b0);
        read_all();
        step(1'b1, 3'd6, 1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1, AW'(k), 1'b0);
        read_all();
        for (int k = 0; k < 60; k++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), DW'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom_range(0, 15) == 0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        read_all();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
